stream_uart_tx: RTL and testbench

Byte-stream UART transmitter with an input FIFO and optional end-of-packet character insertion. It consumes the 8-bit valid/ready/last stream produced by the emitter-side message path and drives the board's UART TX pin in 8N1 format. It decouples bursty stream producers from the slow serial line, so a producer stalls only when the FIFO is full.

---
 rtl/stream_uart_tx.sv | 136 +++++++++++++
 tb/tb_stream_uart_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_uart_tx.sv
// Byte-stream UART transmitter: buffers an 8-bit valid/ready/last stream in a
// FIFO and serialises it 8N1, optionally appending EOL_CHAR after each packet.
module stream_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 16000000,
  parameter int unsigned BAUD        = 57600,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter bit          EOL_EN      = 1'b1,
  parameter logic [7:0]  EOL_CHAR    = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int          CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [PTR_W:0]   FULL_FILL = (PTR_W+1)'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("stream_uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("stream_uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg, state_next;
  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next, fill_next;
  logic             tready_reg, eol_pending_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             tx_reg, tx_next, line_active_reg, busy_reg;

  logic       fifo_empty, push, pop, baud_last, load_slot, load;
  logic [8:0] rd_entry;
  logic [7:0] load_byte;

  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign push        = i_tvalid && tready_reg;
  assign rd_entry    = mem[rd_ptr_reg[PTR_W-1:0]];
  assign baud_last   = (baud_cnt_reg == DIV_LAST);
  // A new frame may be loaded from IDLE or straight out of the last stop cycle.
  assign load_slot   = (state_reg == IDLE) || (state_reg == STOP && baud_last);
  assign load        = load_slot && (eol_pending_reg || !fifo_empty);
  assign pop         = load && !eol_pending_reg;
  assign load_byte   = eol_pending_reg ? EOL_CHAR : rd_entry[7:0];
  assign wr_ptr_next = wr_ptr_reg + (PTR_W+1)'(push);
  assign rd_ptr_next = rd_ptr_reg + (PTR_W+1)'(pop);
  assign fill_next   = wr_ptr_next - rd_ptr_next;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= {i_tlast, i_tdata};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = START;
      START:   if (baud_last) state_next = DATA;
      DATA:    if (baud_last && bit_idx_reg == 3'd7) state_next = STOP;
      STOP:    if (baud_last) state_next = load ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      tready_reg      <= 1'b0;
      eol_pending_reg <= 1'b0;
      baud_cnt_reg    <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      tx_reg          <= 1'b1;
      line_active_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      tready_reg      <= (fill_next != FULL_FILL);
      tx_reg          <= tx_next;
      // The line lags the FSM by one register stage; busy covers that tail.
      line_active_reg <= (state_reg != IDLE);
      busy_reg        <= (state_reg != IDLE) || line_active_reg || !fifo_empty || eol_pending_reg;
      if (load) begin
        shift_reg       <= load_byte;
        baud_cnt_reg    <= '0;
        bit_idx_reg     <= '0;
        eol_pending_reg <= eol_pending_reg ? 1'b0 : (rd_entry[8] & EOL_EN);
      end else if (state_reg != IDLE) begin
        baud_cnt_reg <= baud_last ? '0 : baud_cnt_reg + 1'b1;
        if (state_reg == DATA && baud_last) begin
          shift_reg   <= {1'b0, shift_reg[7:1]};
          bit_idx_reg <= bit_idx_reg + 3'd1;
        end
      end
    end
  end

  assign o_tready  = tready_reg;
  assign o_uart_tx = tx_reg;
  assign o_busy    = busy_reg;

endmodule

// File: tb/tb_stream_uart_tx.sv
// Directed bench for stream_uart_tx: DIV=10 instances with and without EOL
// insertion, plus one instance at default parameters (DIV=277).
module tb_stream_uart_tx;
  localparam int DIV     = 10;
  localparam int DIV_DEF = 16000000 / 57600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       tvalid_a = 1'b0, tvalid_b = 1'b0, tvalid_c = 1'b0;
  logic       tready_a, tready_b, tready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  int         checks = 0;
  int         errors = 0;

  stream_uart_tx #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16),
                   .EOL_EN(1'b1), .EOL_CHAR(8'h0A)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid_a), .o_tready(tready_a), .o_uart_tx(tx_a), .o_busy(busy_a));

  stream_uart_tx #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16),
                   .EOL_EN(1'b0), .EOL_CHAR(8'h0A)) dut_noeol (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid_b), .o_tready(tready_b), .o_uart_tx(tx_b), .o_busy(busy_b));

  stream_uart_tx dut_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid_c), .o_tready(tready_c), .o_uart_tx(tx_c), .o_busy(busy_c));

  // Expected line level at offset 'off' cycles into an 8N1 frame of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int off, input int div);
    int k;
    k = off / div;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
    checks++; if (tready_a !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", tready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    rst_n = 1'b1;
    #1;
    checks++; if (tready_a !== 1'b0) begin errors++; $display("FAIL release_tready_before_edge: got %b expected 0", tready_a); end
    @(posedge clk); #1;
    checks++; if ({tready_a, tready_b, tready_c} !== 3'b111) begin
      errors++; $display("FAIL release_tready_first_edge: got %b expected 111", {tready_a, tready_b, tready_c});
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_after_reset: %0d non-idle cycles, expected 0", bad); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       exp;
    int         bad, first_bad;
    b = 8'h55; bad = 0; first_bad = -1;
    @(negedge clk); tdata = b; tlast = 1'b0; tvalid_a = 1'b1;
    @(posedge clk); #1; tvalid_a = 1'b0;
    for (int n = 0; n < 110; n++) begin
      @(negedge clk);
      exp = (n >= 2 && n < 102) ? frame_bit(b, n - 2, DIV) : 1'b1;
      if (tx_a !== exp) begin bad++; if (first_bad < 0) first_bad = n; end
      if (n == 0) begin checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_w0: got %b expected 0", busy_a); end end
      if (n == 1) begin checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_w1: got %b expected 1", busy_a); end end
      if (n == 102) begin checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_w102: got %b expected 1", busy_a); end end
      if (n == 103) begin checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy_w103: got %b expected 0", busy_a); end end
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL single_line_0x55: %0d wrong cycles (first at W+%0d), expected 0", bad, first_bad);
    end
    $display("test_single byte=0x%02h done", b);
  endtask

  task automatic test_eol();
    logic exp_a, exp_b;
    int   bad_a, bad_b;
    bad_a = 0; bad_b = 0;
    @(negedge clk); tdata = 8'h41; tlast = 1'b1; tvalid_a = 1'b1; tvalid_b = 1'b1;
    @(posedge clk); #1; tvalid_a = 1'b0; tvalid_b = 1'b0; tlast = 1'b0;
    for (int n = 0; n < 215; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 102)        exp_a = frame_bit(8'h41, n - 2, DIV);
      else if (n >= 102 && n < 202) exp_a = frame_bit(8'h0A, n - 102, DIV);
      else                          exp_a = 1'b1;
      exp_b = (n >= 2 && n < 102) ? frame_bit(8'h41, n - 2, DIV) : 1'b1;
      if (tx_a !== exp_a) bad_a++;
      if (tx_b !== exp_b) bad_b++;
      if (n == 202) begin checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL eol_busy_w202: got %b expected 1", busy_a); end end
      if (n == 203) begin checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL eol_busy_w203: got %b expected 0", busy_a); end end
      if (n == 103) begin checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL noeol_busy_w103: got %b expected 0", busy_b); end end
    end
    checks++; if (bad_a != 0) begin errors++; $display("FAIL eol_line_41_0A: %0d wrong cycles, expected 0", bad_a); end
    checks++; if (bad_b != 0) begin errors++; $display("FAIL noeol_line_41: %0d wrong cycles, expected 0", bad_b); end
    $display("test_eol done");
  endtask

  task automatic test_back_to_back();
    int         acc_cyc[$];
    logic [7:0] got[$];
    logic       will;
    int         timeouts, stop_err, bad_first, bad_rate, w;
    logic [7:0] d;
    timeouts = 0; stop_err = 0; bad_first = 0; bad_rate = 0;
    @(negedge clk); tdata = 8'h10; tlast = 1'b0; tvalid_a = 1'b1;
    fork
      begin
        for (int cyc = 0; cyc < 620; cyc++) begin
          if (cyc != 0) @(negedge clk);
          will = tready_a;
          @(posedge clk);
          if (will) begin acc_cyc.push_back(cyc); #1; tdata = tdata + 8'd1; end
        end
        #1; tvalid_a = 1'b0;
      end
      begin
        for (int i = 0; i < 23; i++) begin
          w = 0;
          do begin @(negedge clk); w++; end while (tx_a !== 1'b0 && w < 400);
          if (tx_a !== 1'b0) begin timeouts++; break; end
          repeat (DIV / 2) @(negedge clk);
          if (tx_a !== 1'b0) stop_err++;
          for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            d[k] = tx_a;
          end
          repeat (DIV) @(negedge clk);
          if (tx_a !== 1'b1) stop_err++;
          got.push_back(d);
          $display("rx byte %0d = 0x%02h", i, d);
        end
      end
    join
    checks++; if (acc_cyc.size() != 23) begin errors++; $display("FAIL bp_accept_count: got %0d expected 23", acc_cyc.size()); end
    for (int i = 0; i < acc_cyc.size(); i++) begin
      if (i < 17 && acc_cyc[i] != i) bad_first++;
      if (i == 17 && acc_cyc[i] != 102) bad_rate++;
      if (i > 17 && acc_cyc[i] - acc_cyc[i-1] != 100) bad_rate++;
    end
    checks++; if (bad_first != 0) begin errors++; $display("FAIL bp_first_17_consecutive: %0d bad, expected 0", bad_first); end
    checks++; if (bad_rate != 0) begin errors++; $display("FAIL bp_one_per_frame: %0d bad intervals, expected 0", bad_rate); end
    checks++; if (timeouts != 0 || stop_err != 0) begin
      errors++; $display("FAIL bp_framing: timeouts=%0d framing_errors=%0d expected 0/0", timeouts, stop_err);
    end
    checks++; if (got.size() != 23) begin errors++; $display("FAIL bp_rx_count: got %0d expected 23", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL bp_rx_byte_%0d: got 0x%02h expected 0x%02h", i, got[i], 8'h10 + 8'(i));
      end
    end
    w = 0;
    while (busy_a !== 1'b0 && w < 300) begin @(negedge clk); w++; end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bp_drain_busy: got %b expected 0", busy_a); end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    logic       exp;
    int         bad, bad_frame;
    bad = 0; bad_frame = 0;
    @(negedge clk); tdata = 8'hA5; tlast = 1'b0; tvalid_a = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      tdata = 8'hA0 + 8'(i);
    end
    tvalid_a = 1'b0;
    repeat (41) @(negedge clk);
    checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL ar_bit3_before_reset: got %b expected 0", tx_a); end
    #1; rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL ar_tx_async: got %b expected 1", tx_a); end
    checks++; if (tready_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL ar_tready_busy: got %b%b expected 00", tready_a, busy_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || tready_a !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ar_no_residual: %0d non-idle cycles, expected 0", bad); end
    @(negedge clk); tdata = 8'h3C; tvalid_a = 1'b1;
    @(posedge clk); #1; tvalid_a = 1'b0;
    for (int n = 0; n < 110; n++) begin
      @(negedge clk);
      exp = (n >= 2 && n < 102) ? frame_bit(8'h3C, n - 2, DIV) : 1'b1;
      if (tx_a !== exp) bad_frame++;
    end
    checks++; if (bad_frame != 0) begin errors++; $display("FAIL ar_new_byte_0x3C: %0d wrong cycles, expected 0", bad_frame); end
    $display("test_async_reset done");
  endtask

  task automatic test_default_div();
    logic exp, in_run;
    int   bad, low_len;
    bad = 0; low_len = 0; in_run = 1'b1;
    @(negedge clk); tdata = 8'h55; tlast = 1'b0; tvalid_c = 1'b1;
    @(posedge clk); #1; tvalid_c = 1'b0;
    for (int n = 0; n < 2790; n++) begin
      @(negedge clk);
      exp = (n >= 2 && n < 2 + 10 * DIV_DEF) ? frame_bit(8'h55, n - 2, DIV_DEF) : 1'b1;
      if (tx_c !== exp) bad++;
      if (n >= 2 && in_run) begin
        if (tx_c === 1'b0) low_len++; else in_run = 1'b0;
      end
      if (n == 2 + 10 * DIV_DEF + 1) begin
        checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL def_busy_end: got %b expected 0", busy_c); end
      end
    end
    checks++; if (low_len != 277) begin errors++; $display("FAIL def_bit_period: got %0d expected 277", low_len); end
    checks++; if (bad != 0) begin errors++; $display("FAIL def_frame_2770: %0d wrong cycles, expected 0", bad); end
    $display("test_default_div done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_eol();
    test_back_to_back();
    test_async_reset();
    test_default_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
